// File: rtl/rx_unit_pkg.sv
// Shared definitions for the MiniUart receive path.
// Holds the receive FSM encoding, the default oversample ratio and the
// data width used by rx_unit and its helpers.
package rx_unit_pkg;

    localparam int OVS_DEF = 16;  // oversample ticks per bit
    localparam int DATA_W  = 8;   // 8N1 framing only

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rx_unit_sync.sv
// rx_sync: flop chain that brings the asynchronous serial line into clk.
// All stages preset to 1 (line idle level) on reset so no false start
// bit is seen as reset releases.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset (presets chain to 1)
//   d    - raw asynchronous input
//   q    - synchronised output, STAGES clk later
module rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '1;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++)
                chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rx_unit.sv
// rx_unit: MiniUart receiver, 8N1.
// Oversamples rxd on en_rx ticks, qualifies the start bit at mid-bit,
// shifts 8 data bits LSB-first, samples the stop bit and presents the
// byte with status flags until the bus side reads it with rd.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset
//   rxd    - serial line, idle high
//   en_rx  - oversample tick, OVS ticks per bit
//   rd     - one-cycle read strobe, consumes the byte
//   d_out  - last received byte
//   rs     - unread byte valid
//   fe     - framing error on the byte in d_out (stop bit was 0)
//   oe     - overrun: a frame completed over an unread byte
//   busy   - receiver FSM not idle
module rx_unit
    import rx_unit_pkg::*;
#(
    parameter int OVS         = OVS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic              en_rx,
    input  logic              rd,
    output logic [DATA_W-1:0] d_out,
    output logic              rs,
    output logic              fe,
    output logic              oe,
    output logic              busy
);

    localparam int SW = $clog2(OVS);
    localparam logic [SW-1:0] SMP_HALF = SW'(OVS/2 - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(OVS - 1);

    rx_state_t         state, state_n;
    logic              rxd_s;
    logic [SW-1:0]     smp_cnt;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;

    // control strobes, all qualified by en_rx
    logic smp_clr;   // restart sample counter
    logic bit_clr;   // start of data bits
    logic shift;     // mid-bit sample of a data bit
    logic done;      // mid-bit sample of the stop bit

    rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RX_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        smp_clr = 1'b0;
        bit_clr = 1'b0;
        shift   = 1'b0;
        done    = 1'b0;
        if (en_rx) begin
            case (state)
                RX_IDLE: begin
                    if (!rxd_s) begin
                        state_n = RX_START;
                        smp_clr = 1'b1;
                    end
                end
                RX_START: begin
                    // half a bit after the falling edge: still low means a
                    // real start bit, otherwise a glitch and we drop it
                    if (smp_cnt == SMP_HALF) begin
                        if (!rxd_s) begin
                            state_n = RX_DATA;
                            smp_clr = 1'b1;
                            bit_clr = 1'b1;
                        end else begin
                            state_n = RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    // counter was re-zeroed at mid start bit, so LAST
                    // lands at the middle of each data bit
                    if (smp_cnt == SMP_LAST) begin
                        shift = 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state_n = RX_STOP;
                            smp_clr = 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (smp_cnt == SMP_LAST) begin
                        done    = 1'b1;
                        state_n = RX_IDLE;
                    end
                end
                default: state_n = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (en_rx) begin
            if (smp_clr)
                smp_cnt <= '0;
            else if (state != RX_IDLE)
                smp_cnt <= smp_cnt + 1'b1;
            if (bit_clr)
                bit_cnt <= '0;
            else if (shift)
                bit_cnt <= bit_cnt + 1'b1;
            if (shift)
                shreg <= {rxd_s, shreg[DATA_W-1:1]};
        end
    end

    // Frame completion takes priority over rd: a coincident read consumed
    // the old byte, so the new one is valid and there is no overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out <= '0;
            rs    <= 1'b0;
            fe    <= 1'b0;
            oe    <= 1'b0;
        end else if (done) begin
            d_out <= shreg;
            rs    <= 1'b1;
            fe    <= ~rxd_s;
            oe    <= rs & ~rd;
        end else if (rd && rs) begin
            rs <= 1'b0;
            oe <= 1'b0;
        end
    end

    assign busy = (state != RX_IDLE);

endmodule

// File: tb/tb_rx_unit.sv
// Directed bench for rx_unit: clean frames, latency, start glitch, framing
// error, overrun, coincident read, slow tick rate and mid-frame reset.
module tb_rx_unit;

    localparam int OVS  = 16;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       en_rx = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] d_out;
    logic       rs, fe, oe, busy;

    int n_chk  = 0;
    int n_pass = 0;
    int div    = 1;   // clk per en_rx tick
    int ph     = 0;
    int lat    = 0;

    rx_unit #(.OVS(OVS), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .en_rx (en_rx),
        .rd    (rd),
        .d_out (d_out),
        .rs    (rs),
        .fe    (fe),
        .oe    (oe),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // tick generator: en_rx high one clk in every div
    initial begin
        forever begin
            @(posedge clk); #1;
            ph    = (ph + 1 >= div) ? 0 : ph + 1;
            en_rx = (ph == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        hold(OVS * div);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            hold(OVS * div);
        end
        rxd = stop_bit;
        hold(OVS * div);
        rxd = 1'b1;
        hold(2 * OVS * div);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        hold(1);
        rd = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            hold(1);
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        hold(3);
        chk("rst_dout", d_out, 8'h00);
        chk("rst_rs",   rs,    1'b0);
        chk("rst_fe",   fe,    1'b0);
        chk("rst_oe",   oe,    1'b0);
        chk("rst_busy", busy,  1'b0);
        rst = 1'b1;
        hold(4);

        // 0x55 with ticks every clk; rs must rise 152 + SYNC edges after
        // the first edge that samples the low line (that edge is lat=1)
        fork
            send_frame(8'h55, 1'b1);
            begin
                lat = 0;
                while (!rs && lat < 400) begin
                    hold(1);
                    lat++;
                end
            end
        join
        chk("lat_55",  lat,   1 + 152 + SYNC);
        chk("d_55",    d_out, 8'h55);
        chk("rs_55",   rs,    1'b1);
        chk("fe_55",   fe,    1'b0);
        chk("oe_55",   oe,    1'b0);
        pulse_rd();
        chk("rs_rd55", rs,    1'b0);
        chk("d_rd55",  d_out, 8'h55);

        // start glitch: low for 4 ticks only
        rxd = 1'b0;
        hold(4);
        rxd = 1'b1;
        chk("gl_busy", busy, 1'b1);
        hold(20);
        chk("gl_idle", busy, 1'b0);
        chk("gl_rs",   rs,   1'b0);

        // framing error, then a clean frame clears fe
        send_frame(8'hA3, 1'b0);
        wait_idle("idle_a3");
        chk("d_a3",  d_out, 8'hA3);
        chk("rs_a3", rs,    1'b1);
        chk("fe_a3", fe,    1'b1);
        pulse_rd();
        chk("rs_rda3", rs, 1'b0);
        chk("fe_rda3", fe, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_idle("idle_3c");
        chk("d_3c",  d_out, 8'h3C);
        chk("fe_3c", fe,    1'b0);
        pulse_rd();

        // overrun
        send_frame(8'h12, 1'b1);
        chk("oe_12", oe, 1'b0);
        send_frame(8'h34, 1'b1);
        chk("d_ov",  d_out, 8'h34);
        chk("rs_ov", rs,    1'b1);
        chk("oe_ov", oe,    1'b1);
        pulse_rd();
        chk("rs_ovrd", rs, 1'b0);
        chk("oe_ovrd", oe, 1'b0);

        // rd coincident with completion: completion wins, no overrun
        send_frame(8'h12, 1'b1);
        fork
            send_frame(8'h34, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 rd = 1'b1;
                hold(1);
                rd = 1'b0;
            end
        join
        chk("d_co",  d_out, 8'h34);
        chk("rs_co", rs,    1'b1);
        chk("oe_co", oe,    1'b0);

        // reset during data bit 3 of 0xF8 (line stays high after bit 2)
        fork
            send_frame(8'hF8, 1'b1);
            begin
                hold(72);
                chk("mid_busy", busy, 1'b1);
                rst = 1'b0;
                hold(2);
                chk("mr_dout", d_out, 8'h00);
                chk("mr_rs",   rs,    1'b0);
                chk("mr_fe",   fe,    1'b0);
                chk("mr_oe",   oe,    1'b0);
                chk("mr_busy", busy,  1'b0);
                rst = 1'b1;
            end
        join
        chk("mr_rs2", rs, 1'b0);
        send_frame(8'h81, 1'b1);
        chk("d_81",  d_out, 8'h81);
        chk("rs_81", rs,    1'b1);
        chk("fe_81", fe,    1'b0);
        pulse_rd();

        // slow ticks: one en_rx every 4 clk
        div = 4;
        hold(8);
        send_frame(8'hF0, 1'b1);
        wait_idle("idle_f0");
        chk("d_f0",  d_out, 8'hF0);
        chk("rs_f0", rs,    1'b1);
        chk("fe_f0", fe,    1'b0);
        chk("oe_f0", oe,    1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rx_unit.md
Name: rx_unit

Overview:
UART receive unit for MiniUart, the counterpart of the transmit unit.
- Oversamples the serial input `rxd` on an `en_rx` tick, validates the start bit at mid-bit and deserialises 8 data bits LSB-first.
- Checks the stop bit, then presents the byte in parallel with status flags.
- Sits between the pad `rxd` and the MiniUart register/bus interface, which reads the byte with a one-cycle `rd` strobe.

Parameters:
- OVS, 16, oversample ticks per bit; power of 2, at least 4.
- SYNC_STAGES, 2, flip-flop stages on `rxd` before use.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low. One clock domain, `clk`; the `rst` polarity and asynchronous behaviour are fixed.
- rxd  input  1  serial line, idle high.
- en_rx  input  1  oversample tick, one `clk` wide, OVS ticks per bit.
- rd  input  1  read strobe from the bus side; consumes the byte.
- d_out  output  8  last received byte.
- rs  output  1  receive status; 1 = unread byte valid.
- fe  output  1  framing error on the last frame (stop bit sampled 0).
- oe  output  1  overrun; a frame completed while rs=1 and no rd in the same cycle.
- busy  output  1  FSM not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM=IDLE; sample counter and bit counter cleared.
  - Synchroniser stages set to 1; shift register cleared to 0.
  - d_out=0x00, rs=0, fe=0, oe=0, busy=0.
  - Reset asserted mid-frame aborts the frame with no partial update of the outputs.
- Synchroniser: `rxd` passes through SYNC_STAGES flops to give `rxd_s`. All decisions use `rxd_s`.
- Counters:
  - smp_cnt is log2(OVS) bits and advances only on en_rx; it wraps naturally at OVS-1 -> 0.
  - bit_cnt is 3 bits.
  - With en_rx=0, nothing changes apart from rd handling.
- IDLE:
  - On en_rx with rxd_s=0: go to START, smp_cnt<=0.
- START:
  - On en_rx: smp_cnt++.
  - At smp_cnt==OVS/2-1, resample. If rxd_s=0: go to DATA, smp_cnt<=0, bit_cnt<=0.
  - Otherwise this is a glitch: return to IDLE with no flag change.
- DATA:
  - On en_rx: smp_cnt++.
  - At smp_cnt==OVS-1 (mid-bit): shift register <= {rxd_s, shreg[7:1]}, bit_cnt++.
  - When bit_cnt==7 at that point: go to STOP, smp_cnt<=0.
- STOP:
  - At smp_cnt==OVS-1: d_out<=shreg, rs<=1, fe<=~rxd_s.
  - oe<=1 if rs=1 and rd=0 in that cycle; otherwise oe<=0.
  - Go to IDLE.
  - A stop bit sampled 0 (break) still completes the frame. IDLE then re-arms immediately, so a held-low line yields repeated 0x00 frames with fe=1.
- rd:
  - Clears rs and oe on the next edge; fe is unchanged (fe describes the byte in d_out).
  - rd with rs=0 has no effect.
- rd in the same cycle as frame completion: completion wins. rs stays 1, d_out takes the new byte, oe=0 (the old byte was consumed).
- Latency: the rxd_s falling edge is seen on the first en_rx. rs rises OVS/2 + 9*OVS ticks later (plus SYNC_STAGES clk of input delay).
- Outputs are all registered. busy is combinational from the FSM state.
- Only 8N1 framing is supported; there is no parity.

Decomposition:
- Shared header `head_uart.v`:
  - FSM encodings RX_IDLE=0, RX_START=1, RX_DATA=2, RX_STOP=3.
  - OVS default.
  - Data width 8.
- Sub-module `rx_sync`: parameterised SYNC_STAGES flop chain with an asynchronous active-low preset to 1.
- FSM, counters and shift register stay in `rx_unit`.

Test Plan:
- OVS=16, en_rx tied 1 (bit = 16 clk), send 0x55 with stop=1 -> d_out=0x55, rs=1, fe=0, oe=0; rs rises 152 clk + sync after the start edge.
- rxd low for 4 en_rx ticks, then high -> FSM returns to IDLE, busy falls, rs stays 0.
- Send 0xA3 with stop bit driven 0 -> d_out=0xA3, rs=1, fe=1. Next clean frame 0x3C -> fe=0.
- Overrun and simultaneous read:
  - Send 0x12, then 0x34 without rd -> d_out=0x34, oe=1. Pulse rd -> rs=0, oe=0.
  - Repeat with rd coincident with the 0x34 completion -> rs=1, oe=0.
- en_rx every 4th clk, send 0xF0 -> same result as the tick-every-clk case; no state change on non-tick cycles.
- rst pulsed low during data bit 3 -> all outputs zero, busy=0. A following frame 0x81 is received correctly.
